// File: rtl/encoder8x3_stream.sv
// -----------------------------------------------------------------------------
// encoder8x3_stream
//
// Serialising N-to-W encoder. It accepts a multi-hot request vector and then
// emits the index of every set bit, one index per valid/ready beat. out_last
// flags the final index of the vector. A vector with no bits set produces no
// beats; instead, none pulses high for a single cycle.
//
// Compile-time option:
//   ENC_MSB_FIRST_EN  defined   -> indices are emitted highest set bit first
//                     undefined -> indices are emitted lowest set bit first
//
// Parameters:
//   N  request vector width (power of two, >= 2)
//   W  index width, equal to $clog2(N)
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset; overrides everything
//   en         in   enable; gates acceptance of new vectors only
//   in         in   [N-1:0] request vector
//   in_valid   in   request vector valid
//   in_ready   out  block can accept a vector (combinational)
//   out        out  [W-1:0] index of the current beat
//   out_valid  out  out is valid
//   out_ready  in   sink accepts the current beat
//   out_last   out  current beat is the final set bit of the vector
//   none       out  one-cycle pulse: the accepted vector was all-zero
// -----------------------------------------------------------------------------
module encoder8x3_stream #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] in,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         none
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t       state_reg, state_next;
    logic [N-1:0] mask_reg, mask_next;
    logic [W-1:0] out_reg, out_next;
    logic         out_valid_reg, out_valid_next;
    logic         out_last_reg, out_last_next;
    logic         none_reg, none_next;

    // One-hot of the bit being emitted this cycle. While in EMIT, out_reg always
    // holds the index picked from mask_reg, so decoding it avoids a second
    // priority picker on the current mask.
    logic [N-1:0] beat_onehot;

    // Index of the set bit that goes out first in the configured order.
    // The loop direction makes the last match win, which is the priority bit.
    function automatic logic [W-1:0] pick_index(input logic [N-1:0] m);
        logic [W-1:0] idx;
        idx = '0;
`ifdef ENC_MSB_FIRST_EN
        for (int i = 0; i < N; i++) begin
            if (m[i]) idx = W'(i);
        end
`else
        for (int i = N - 1; i >= 0; i--) begin
            if (m[i]) idx = W'(i);
        end
`endif
        return idx;
    endfunction

    // True when exactly one bit is set. m & (m - 1) removes the lowest set bit.
    function automatic logic is_single(input logic [N-1:0] m);
        return (m != '0) && ((m & (m - 1'b1)) == '0);
    endfunction

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_beat_decode
            assign beat_onehot[gi] = (out_reg == W'(gi));
        end
    endgenerate

    // ------------------------------------------------------------------
    // State register. Holds the FSM state, the remaining-bits mask and
    // all registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            mask_reg      <= '0;
            out_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            none_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            mask_reg      <= mask_next;
            out_reg       <= out_next;
            out_valid_reg <= out_valid_next;
            out_last_reg  <= out_last_next;
            none_reg      <= none_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        mask_next  = mask_reg;
        none_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (in_valid && in_ready) begin
                    mask_next = in;
                    if (in == '0) begin
                        none_next = 1'b1;
                    end else begin
                        state_next = EMIT;
                    end
                end
            end
            EMIT: begin
                if (out_valid_reg && out_ready) begin
                    mask_next = mask_reg & ~beat_onehot;
                    if (out_last_reg) begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                mask_next  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic. The beat outputs are computed from the next mask, so
    // the first index appears one cycle after accept. After a non-last
    // transfer the following index is presented with no bubble. With no
    // transfer the mask is unchanged, so the outputs stay stable under
    // backpressure.
    // ------------------------------------------------------------------
    always_comb begin
        in_ready       = (state_reg == IDLE) && en && !rst;
        out_valid_next = (state_next == EMIT);
        out_next       = '0;
        out_last_next  = 1'b0;
        if (state_next == EMIT) begin
            out_next      = pick_index(mask_next);
            out_last_next = is_single(mask_next);
        end
    end

    assign out       = out_reg;
    assign out_valid = out_valid_reg;
    assign out_last  = out_last_reg;
    assign none      = none_reg;

endmodule

// File: tb/tb_encoder8x3_stream.sv
// -----------------------------------------------------------------------------
// tb_encoder8x3_stream
//
// Directed self-checking bench for encoder8x3_stream. Inputs change 1 ns after
// each rising edge. Outputs are sampled at the same point, which is well clear
// of the active edge. Each transaction prints one line. The build with
// ENC_MSB_FIRST_EN defined uses reversed expected index orders.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_encoder8x3_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] in;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] out;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       none;

    int checks = 0;
    int errors = 0;

    encoder8x3_stream #(.N(8), .W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in        (in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .none      (none)
    );

    always #5 clk = ~clk;

    // Advance one cycle; stimulus and sampling happen 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; in = 8'h00; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        checks++;
        if ({out_valid, out, out_last, none} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs got valid=%b out=%0d last=%b none=%b want all 0", out_valid, out, out_last, none);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
        $display("test_reset done");
    endtask

    task automatic test_single_bit();
        in = 8'b0000_0001; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out, out_last, in_ready} !== {1'b1, 3'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL t1_beat got valid=%b out=%0d last=%b in_ready=%b want 1 0 1 0", out_valid, out, out_last, in_ready);
        end
        $display("t1 beat out=%0d last=%b", out, out_last);
        tick();
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL t1_idle got valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_multi_bit();
        logic [2:0] exp_idx [3];
`ifdef ENC_MSB_FIRST_EN
        exp_idx = '{3'd7, 3'd5, 3'd2};
`else
        exp_idx = '{3'd2, 3'd5, 3'd7};
`endif
        in = 8'b1010_0100; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({out_valid, out, out_last, in_ready} !== {1'b1, exp_idx[k], (k == 2), 1'b0}) begin
                errors++;
                $display("FAIL t2_beat%0d got valid=%b out=%0d last=%b in_ready=%b want 1 %0d %b 0",
                         k, out_valid, out, out_last, in_ready, exp_idx[k], (k == 2));
            end
            $display("t2 beat%0d out=%0d last=%b", k, out, out_last);
            tick();
        end
        checks++;
        if ({out_valid, out_last, in_ready} !== 3'b001) begin
            errors++;
            $display("FAIL t2_end got valid=%b last=%b in_ready=%b want 0 0 1", out_valid, out_last, in_ready);
        end
    endtask

    task automatic test_backpressure();
        logic [2:0] exp_first, exp_final;
`ifdef ENC_MSB_FIRST_EN
        exp_first = 3'd7; exp_final = 3'd2;
`else
        exp_first = 3'd2; exp_final = 3'd7;
`endif
        in = 8'b1010_0100; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out !== exp_first) begin errors++; $display("FAIL t3_first got %0d want %0d", out, exp_first); end
        tick();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({out_valid, out, out_last} !== {1'b1, 3'd5, 1'b0}) begin
                errors++;
                $display("FAIL t3_hold%0d got valid=%b out=%0d last=%b want 1 5 0", k, out_valid, out, out_last);
            end
            $display("t3 hold%0d out=%0d ready=%b", k, out, out_ready);
            if (k == 2) out_ready = 1'b1;
            if (k < 3) begin
                if (k != 2) tick();
                else #0;
            end
        end
        tick();
        checks++;
        if ({out_valid, out, out_last} !== {1'b1, exp_final, 1'b1}) begin
            errors++;
            $display("FAIL t3_resume got valid=%b out=%0d last=%b want 1 %0d 1", out_valid, out, out_last, exp_final);
        end
        $display("t3 resume out=%0d last=%b", out, out_last);
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL t3_end got valid=%b want 0", out_valid); end
    endtask

    task automatic test_zero_vector();
        in = 8'h00; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if ({none, out_valid, in_ready} !== 3'b101) begin
            errors++;
            $display("FAIL t4_pulse got none=%b valid=%b in_ready=%b want 1 0 1", none, out_valid, in_ready);
        end
        $display("t4 none=%b", none);
        tick();
        checks++;
        if ({none, out_valid, in_ready} !== 3'b001) begin
            errors++;
            $display("FAIL t4_after got none=%b valid=%b in_ready=%b want 0 0 1", none, out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_stream();
        logic [2:0] exp_idx [3];
`ifdef ENC_MSB_FIRST_EN
        exp_idx = '{3'd7, 3'd6, 3'd5};
`else
        exp_idx = '{3'd0, 3'd1, 3'd2};
`endif
        in = 8'hFF; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({out_valid, out, out_last} !== {1'b1, exp_idx[k], 1'b0}) begin
                errors++;
                $display("FAIL t5_beat%0d got valid=%b out=%0d last=%b want 1 %0d 0", k, out_valid, out, out_last, exp_idx[k]);
            end
            $display("t5 beat%0d out=%0d", k, out);
            tick();
        end
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL t5_rst_in_ready got %b want 0", in_ready); end
        tick();
        checks++;
        if ({out_valid, out, out_last} !== 5'b0) begin
            errors++;
            $display("FAIL t5_after_rst got valid=%b out=%0d last=%b want 0 0 0", out_valid, out, out_last);
        end
        rst = 1'b0;
        in = 8'h80; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out, out_last} !== {1'b1, 3'd7, 1'b1}) begin
            errors++;
            $display("FAIL t5_single got valid=%b out=%0d last=%b want 1 7 1", out_valid, out, out_last);
        end
        $display("t5 post-reset out=%0d last=%b", out, out_last);
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL t5_end got valid=%b want 0", out_valid); end
    endtask

    task automatic test_enable_gating();
        logic [2:0] exp_idx [4];
`ifdef ENC_MSB_FIRST_EN
        exp_idx = '{3'd3, 3'd2, 3'd1, 3'd0};
`else
        exp_idx = '{3'd0, 3'd1, 3'd2, 3'd3};
`endif
        en = 1'b0; in = 8'h0F; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({in_ready, out_valid} !== 2'b00) begin
                errors++;
                $display("FAIL t6_gated%0d got in_ready=%b valid=%b want 0 0", k, in_ready, out_valid);
            end
            tick();
        end
        en = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL t6_enable got in_ready=%b want 1", in_ready); end
        tick();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({out_valid, out, out_last, in_ready} !== {1'b1, exp_idx[k], (k == 3), 1'b0}) begin
                errors++;
                $display("FAIL t6_beat%0d got valid=%b out=%0d last=%b in_ready=%b want 1 %0d %b 0",
                         k, out_valid, out, out_last, in_ready, exp_idx[k], (k == 3));
            end
            $display("t6 beat%0d out=%0d last=%b en=%b", k, out, out_last, en);
            tick();
            en = 1'b0;
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({out_valid, in_ready} !== 2'b00) begin
                errors++;
                $display("FAIL t6_no_accept%0d got valid=%b in_ready=%b want 0 0", k, out_valid, in_ready);
            end
            tick();
        end
        in_valid = 1'b0;
        en = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_bit();
        test_multi_bit();
        test_backpressure();
        test_zero_vector();
        test_reset_mid_stream();
        test_enable_gating();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
